fma_cluster: RTL and testbench
==============================

# fma_cluster

A compute cluster of `FMA_COUNT` fixed-point fused multiply-accumulate lanes. It also contains a write buffer that packs lane results into memory-width lines. It sits between the `memory` block, which supplies operand lines and control, and the `memory` write-back port, which consumes `line_out`/`line_valid_out`. The `controller` lives outside this block and only influences it through `memory`.

## Interface
- `FMA_COUNT`, 2: number of lanes.
- `WORD_WIDTH`, 16: word width; signed two's-complement fixed point.
- `FIXED_POINT`, 10: fractional bits.
- `LINE_WIDTH`, 96: must equal 3·WORD_WIDTH·FMA_COUNT.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-high.
- `abc_in` in LINE_WIDTH: operands. Lane i uses `abc_in[LINE_WIDTH-1-i·3W -: 3W]`, so lane 0 sits at the MSBs. Each slice is `{a,b,c}` with `a` most significant.
- `valid_in` in 1: operands valid, shared by all lanes.
- `c_valid_in` in 1: load `c` as the accumulator base instead of the running sum.
- `output_can_be_valid_in` in 1: permits `fma_valid_out` to assert.
- `fma_out` out W·FMA_COUNT: lane results, lane 0 at the MSBs.
- `fma_valid_out` out FMA_COUNT: per-lane result valid, lane 0 at the MSB.
- `line_out` out LINE_WIDTH: packed line.
- `line_valid_out` out 1: one-cycle pulse when a line completes.

## Operation
- **Lane, on a `valid_in` edge:**
  - prod = (a·b as a signed 2W product) >>> FIXED_POINT, arithmetic (floor), truncated to W bits.
  - acc ← (`c_valid_in` ? c : acc) + prod, wrapping modulo 2^W with no saturation.
- **Lane, otherwise:** acc holds.
- **Lane outputs:**
  - `fma_out` lane = acc.
  - `fma_valid_out` lane ← `valid_in` & `output_can_be_valid_in`, registered.
  - The accumulator updates even when `output_can_be_valid_in`=0.
- **Write buffer, state:** a capture counter cnt ∈ {0,1,2}.
- **Write buffer, on an edge where all `fma_valid_out` bits are 1:**
  - capture `fma_out` into slot cnt.
  - Slot 0 occupies `line_out` MSBs: `line_out` = {slot0, slot1, slot2}.
  - cnt increments.
- **Write buffer, on the 3rd capture:**
  - cnt → 0 and the completed line is copied to `line_out`.
  - `line_valid_out`=1 for exactly one cycle.
- **Write buffer, partial-valid cycles** (not all lanes valid): ignored, no capture.
- **Write buffer, holding:** `line_out` holds until the next line completes. Slots never leak partial data to `line_out`.
- **Reset:** clears all accumulators, `fma_out`, `fma_valid_out`, cnt, slots, `line_out` and `line_valid_out` to 0.
  - Reset mid-line discards the partial line.

## Timing
- Operand sampled at edge k → `fma_out` and `fma_valid_out` are valid after edge k (1-cycle latency).
- Write buffer samples `fma_valid_out` at edge k+1.
- Three consecutive valid operands at edges 0, 1, 2:
  - captures occur at edges 1, 2, 3.
  - `line_out` and `line_valid_out`=1 appear after edge 3; the pulse drops after edge 4.
- Back-to-back operands give one line every 3 cycles, with no bubbles required.
- `c_valid_in` and `output_can_be_valid_in` are sampled only on the same edge as `valid_in`.

## Structure
- Package `fma_pkg`:
  - default constants WORD_WIDTH=16, FIXED_POINT=10, FMA_COUNT=2.
  - typedef `word_t` (signed logic [WORD_WIDTH-1:0]).
  - a helper function for the fixed-point multiply.
- Sub-module `fma_lane`: one accumulator lane, instantiated FMA_COUNT times via generate.
- The write buffer stays inline in `fma_cluster`.

## Test plan
- **Basic FMA:** a=0x0400 (1.0), b=0x0800 (2.0), c=0x0200 with `c_valid_in`=1, `output_can_be_valid_in`=1 → next cycle `fma_out` lane=0x0A00, valid=1.
- **Accumulate:** the next op with a=b=0x0400 and `c_valid_in`=0 → 0x0E00. A negative op with a=0xFC00, b=0x0200, c=0, `c_valid_in`=1 → 0xFE00.
- **Gating and wrap:**
  - `output_can_be_valid_in`=0 → `fma_valid_out`=0 while acc still updates.
  - acc 0x7C00 + prod 0x0800 → 0x8400 (wraps).
- **Line assembly:** three consecutive ops on both lanes with lane results (1,2), (3,4), (5,6) → after the 3rd capture `line_out`={1,2,3,4,5,6} as 16-bit words from the MSB, and `line_valid_out` is high for exactly 1 cycle.
- **Gaps:** valid ops separated by idle cycles → the line still completes after 3 captures, with no spurious pulse.
- **Reset:** assert `rst_in` asynchronously after 2 captures → all outputs 0 immediately. The next 3 captures form a fresh line containing no stale data.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared constants, word type and the fixed-point multiply used by every lane.
package fma_pkg;

   localparam int WORD_WIDTH  = 16;
   localparam int FIXED_POINT = 10;
   localparam int FMA_COUNT   = 2;

   typedef logic signed [WORD_WIDTH-1:0] word_t;

   // Signed product of two sign-extended words, shifted right arithmetically
   // by the number of fractional bits. The arithmetic shift rounds toward
   // minus infinity. Callers keep the low word of the result.
   function automatic logic signed [63:0] fx_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned frac);
      logic signed [63:0] p;
      p = 64'(a) * 64'(b);
      return p >>> frac;
   endfunction

endpackage

// File: rtl/fma_cluster_if.sv
// Operand/result bundle between the memory block and the FMA cluster.
//
// Handshake: valid-only, with no backpressure. The memory side presents
// abc_in together with valid_in, c_valid_in and output_can_be_valid_in, and
// the cluster consumes them on every rising clock edge where valid_in is 1.
// Results (fma_out/fma_valid_out) and packed lines (line_out/line_valid_out)
// are registered. A line is announced by a single-cycle line_valid_out pulse,
// and the write-back port has to accept it in that cycle.
// wb_cnt exposes the write-buffer capture count (0..2) for observation.
interface fma_cluster_if #(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16,
   parameter int LINE_WIDTH = 96
);
   logic [LINE_WIDTH-1:0]           abc_in;
   logic                            valid_in;
   logic                            c_valid_in;
   logic                            output_can_be_valid_in;
   logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out;
   logic [FMA_COUNT-1:0]            fma_valid_out;
   logic [LINE_WIDTH-1:0]           line_out;
   logic                            line_valid_out;
   logic [1:0]                      wb_cnt;

   modport master (
      output abc_in, valid_in, c_valid_in, output_can_be_valid_in,
      input  fma_out, fma_valid_out, line_out, line_valid_out, wb_cnt
   );

   modport slave (
      input  abc_in, valid_in, c_valid_in, output_can_be_valid_in,
      output fma_out, fma_valid_out, line_out, line_valid_out, wb_cnt
   );
endinterface

// File: rtl/fma_lane.sv
// One fixed-point multiply-accumulate lane. acc <= (c_valid ? c : acc) + a*b,
// and the sum wraps modulo 2^W.
module fma_lane
   import fma_pkg::*;
#(
   parameter int WORD_WIDTH  = fma_pkg::WORD_WIDTH,
   parameter int FIXED_POINT = fma_pkg::FIXED_POINT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic                  c_valid,
   input  logic                  out_en,
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   input  logic [WORD_WIDTH-1:0] c,
   output logic [WORD_WIDTH-1:0] acc,
   output logic                  acc_valid
);

   logic [WORD_WIDTH-1:0] prod;
   logic [WORD_WIDTH-1:0] acc_next;

   // Truncate the floored fixed-point product to one word, then add it to
   // either the fresh base c or the running sum.
   always_comb begin
      prod     = WORD_WIDTH'(fx_mul(32'($signed(a)), 32'($signed(b)), FIXED_POINT));
      acc_next = (c_valid ? c : acc) + prod;
   end

   // The accumulator advances on every valid operand. The output gate only
   // masks the valid flag and does not stop the accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         acc_valid <= 1'b0;
      end else begin
         acc_valid <= valid & out_en;
         if (valid) begin
            acc <= acc_next;
         end
      end
   end

endmodule

// File: rtl/fma_cluster.sv
// FMA_COUNT accumulator lanes plus a write buffer that packs three complete
// lane-result words into one memory line.
module fma_cluster
   import fma_pkg::*;
#(
   parameter int FMA_COUNT   = fma_pkg::FMA_COUNT,
   parameter int WORD_WIDTH  = fma_pkg::WORD_WIDTH,
   parameter int FIXED_POINT = fma_pkg::FIXED_POINT,
   parameter int LINE_WIDTH  = 3 * WORD_WIDTH * FMA_COUNT
) (
   input  logic         clk_in,
   input  logic         rst_in,
   fma_cluster_if.slave bus
);

   localparam int W  = WORD_WIDTH;
   localparam int RW = W * FMA_COUNT;

   logic [W-1:0]         lane_acc   [FMA_COUNT];
   logic                 lane_valid [FMA_COUNT];
   logic [RW-1:0]        fma_vec;
   logic [FMA_COUNT-1:0] valid_vec;
   logic                 all_valid;

   logic [1:0]            cnt;
   logic [RW-1:0]         slot0;
   logic [RW-1:0]         slot1;
   logic [LINE_WIDTH-1:0] line;
   logic                  line_valid;

   // Lane i takes its {a,b,c} slice counting down from the MSBs.
   for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
      logic [3*W-1:0] abc;
      assign abc = bus.abc_in[LINE_WIDTH-1-i*3*W -: 3*W];

      fma_lane #(
         .WORD_WIDTH (W),
         .FIXED_POINT(FIXED_POINT)
      ) u_lane (
         .clk      (clk_in),
         .rst      (rst_in),
         .valid    (bus.valid_in),
         .c_valid  (bus.c_valid_in),
         .out_en   (bus.output_can_be_valid_in),
         .a        (abc[3*W-1 -: W]),
         .b        (abc[2*W-1 -: W]),
         .c        (abc[W-1:0]),
         .acc      (lane_acc[i]),
         .acc_valid(lane_valid[i])
      );
   end

   // Pack the lane results so that lane 0 sits at the MSBs.
   always_comb begin
      fma_vec   = '0;
      valid_vec = '0;
      for (int i = 0; i < FMA_COUNT; i++) begin
         fma_vec[(FMA_COUNT-1-i)*W +: W] = lane_acc[i];
         valid_vec[FMA_COUNT-1-i]        = lane_valid[i];
      end
      all_valid = &valid_vec;
   end

   // Write buffer. It captures only when every lane is valid. The third
   // capture bypasses its slot and publishes the line directly, so a line
   // can complete every third cycle and partial lines never reach line_out.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt        <= 2'd0;
         slot0      <= '0;
         slot1      <= '0;
         line       <= '0;
         line_valid <= 1'b0;
      end else begin
         line_valid <= 1'b0;
         if (all_valid) begin
            case (cnt)
               2'd0: begin
                  slot0 <= fma_vec;
                  cnt   <= 2'd1;
               end
               2'd1: begin
                  slot1 <= fma_vec;
                  cnt   <= 2'd2;
               end
               default: begin
                  line       <= {slot0, slot1, fma_vec};
                  line_valid <= 1'b1;
                  cnt        <= 2'd0;
               end
            endcase
         end
      end
   end

   assign bus.fma_out        = fma_vec;
   assign bus.fma_valid_out  = valid_vec;
   assign bus.line_out       = line;
   assign bus.line_valid_out = line_valid;
   assign bus.wb_cnt         = cnt;

endmodule

// File: tb/tb_fma_cluster.sv
// Directed bench for fma_cluster: lane arithmetic, gating, wrap, line packing,
// gaps between operands and asynchronous reset in the middle of a line.
module tb_fma_cluster;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   fma_cluster_if #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96)) bus ();

   fma_cluster dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (bus)
   );

   // Clock: 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [95:0] ops(input logic [15:0] a0, input logic [15:0] b0,
                                       input logic [15:0] c0, input logic [15:0] a1,
                                       input logic [15:0] b1, input logic [15:0] c1);
      return {a0, b0, c0, a1, b1, c1};
   endfunction

   function automatic logic [95:0] ln(input logic [15:0] w0, input logic [15:0] w1,
                                      input logic [15:0] w2, input logic [15:0] w3,
                                      input logic [15:0] w4, input logic [15:0] w5);
      return {w0, w1, w2, w3, w4, w5};
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one cycle of inputs at a negedge and return at the next negedge.
   task automatic drive(input logic [95:0] abc, input logic v, input logic cv, input logic ok);
      bus.abc_in                 = abc;
      bus.valid_in               = v;
      bus.c_valid_in             = cv;
      bus.output_can_be_valid_in = ok;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(96'h0, 1'b0, 1'b0, 1'b0);
   endtask

   // Operand that loads c directly into each lane (a=b=0, product 0).
   task automatic load(input logic [15:0] c0, input logic [15:0] c1);
      drive(ops(16'h0, 16'h0, c0, 16'h0, 16'h0, c1), 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.abc_in                 = '0;
      bus.valid_in               = 1'b0;
      bus.c_valid_in             = 1'b0;
      bus.output_can_be_valid_in = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_fma_out", 96'(bus.fma_out), 96'h0);
      check("rst_fma_valid", 96'(bus.fma_valid_out), 96'h0);
      check("rst_line_out", bus.line_out, 96'h0);
      check("rst_line_valid", 96'(bus.line_valid_out), 96'h0);
      rst = 1'b0;
      @(negedge clk);

      // Basic FMA: lane0 1.0*2.0+0x200 = 0xA00, lane1 1.0*1.0+0 = 0x400
      drive(ops(16'h0400, 16'h0800, 16'h0200, 16'h0400, 16'h0400, 16'h0000), 1'b1, 1'b1, 1'b1);
      check("basic_fma_out", 96'(bus.fma_out), 96'h0A00_0400);
      check("basic_valid", 96'(bus.fma_valid_out), 96'h3);

      // Accumulate: lane0 +1.0 -> 0xE00, lane1 +4.0 -> 0x1400
      drive(ops(16'h0400, 16'h0400, 16'h0000, 16'h0800, 16'h0800, 16'h0000), 1'b1, 1'b0, 1'b1);
      check("accum_fma_out", 96'(bus.fma_out), 96'h0E00_1400);
      check("accum_wb_cnt", 96'(bus.wb_cnt), 96'h1);

      // Negative: lane0 -1.0*0.5 = 0xFE00, lane1 -1.0*-1.0+0x100 = 0x500
      drive(ops(16'hFC00, 16'h0200, 16'h0000, 16'hFC00, 16'hFC00, 16'h0100), 1'b1, 1'b1, 1'b1);
      check("neg_fma_out", 96'(bus.fma_out), 96'hFE00_0500);
      check("neg_line_valid", 96'(bus.line_valid_out), 96'h0);

      // Gated: accumulators still move (0xFE00+0x400=0x200), valid stays low.
      // This edge is the third capture of the three results above.
      drive(ops(16'h0400, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b1, 1'b0, 1'b0);
      check("gate_fma_out", 96'(bus.fma_out), 96'h0200_0500);
      check("gate_valid", 96'(bus.fma_valid_out), 96'h0);
      check("line1_out", bus.line_out, ln(16'h0A00, 16'h0400, 16'h0E00, 16'h1400, 16'hFE00, 16'h0500));
      check("line1_pulse", 96'(bus.line_valid_out), 96'h1);

      // Idle with junk operands: accumulators hold, pulse drops, line holds
      drive(ops(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111, 16'h2222), 1'b0, 1'b1, 1'b1);
      check("hold_fma_out", 96'(bus.fma_out), 96'h0200_0500);
      check("line1_pulse_drop", 96'(bus.line_valid_out), 96'h0);
      check("line1_hold", bus.line_out, ln(16'h0A00, 16'h0400, 16'h0E00, 16'h1400, 16'hFE00, 16'h0500));

      // Wrap: 0x7C00 + 2.0 -> 0x8400. Floor: lane1 1 LSB * -1 LSB -> 0xFFFF
      drive(ops(16'h0400, 16'h0800, 16'h7C00, 16'h0001, 16'hFFFF, 16'h0000), 1'b1, 1'b1, 1'b0);
      check("wrap_floor_fma_out", 96'(bus.fma_out), 96'h8400_FFFF);
      check("wrap_valid_gated", 96'(bus.fma_valid_out), 96'h0);

      // Line assembly, back to back: (1,2) (3,4) (5,6)
      load(16'd1, 16'd2);
      check("asm1_fma_out", 96'(bus.fma_out), 96'h0001_0002);
      check("asm1_wb_cnt", 96'(bus.wb_cnt), 96'h0);
      load(16'd3, 16'd4);
      load(16'd5, 16'd6);
      check("asm3_no_leak", bus.line_out, ln(16'h0A00, 16'h0400, 16'h0E00, 16'h1400, 16'hFE00, 16'h0500));
      check("asm3_no_pulse", 96'(bus.line_valid_out), 96'h0);
      idle();
      check("line2_out", bus.line_out, ln(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6));
      check("line2_pulse", 96'(bus.line_valid_out), 96'h1);
      idle();
      check("line2_pulse_drop", 96'(bus.line_valid_out), 96'h0);
      check("line2_hold", bus.line_out, ln(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6));

      // Gaps between valid operands
      load(16'd7, 16'd8);
      idle();
      check("gap1_no_pulse", 96'(bus.line_valid_out), 96'h0);
      load(16'd9, 16'd10);
      idle();
      check("gap2_no_pulse", 96'(bus.line_valid_out), 96'h0);
      check("gap2_wb_cnt", 96'(bus.wb_cnt), 96'h2);
      load(16'd11, 16'd12);
      idle();
      check("line3_out", bus.line_out, ln(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12));
      check("line3_pulse", 96'(bus.line_valid_out), 96'h1);
      idle();
      check("line3_pulse_drop", 96'(bus.line_valid_out), 96'h0);

      // Reset after two captures of a new line
      load(16'd13, 16'd14);
      load(16'd15, 16'd16);
      load(16'd17, 16'd18);
      rst = 1'b1;
      #1;
      check("arst_fma_out", 96'(bus.fma_out), 96'h0);
      check("arst_fma_valid", 96'(bus.fma_valid_out), 96'h0);
      check("arst_line_out", bus.line_out, 96'h0);
      check("arst_line_valid", 96'(bus.line_valid_out), 96'h0);
      check("arst_wb_cnt", 96'(bus.wb_cnt), 96'h0);
      bus.valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Fresh line after reset must hold no stale slot data
      load(16'd21, 16'd22);
      load(16'd23, 16'd24);
      load(16'd25, 16'd26);
      check("post_rst_no_leak", bus.line_out, 96'h0);
      idle();
      check("line4_out", bus.line_out, ln(16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26));
      check("line4_pulse", 96'(bus.line_valid_out), 96'h1);
      idle();
      check("line4_pulse_drop", 96'(bus.line_valid_out), 96'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
